mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Core-side request/response handshake and data-memory bus of the memory access unit.
// The unit connects through the slave modport; the core/memory side uses master.
interface mem_access_unit_if #(
  parameter int ADDR_W = 6
);
  // Core request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  // Core response channel
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  // Data memory bus
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store unit in front of a word-wide data memory with a
// combinational read port. Sub-word stores are done as read-modify-write.
//
// Handshake: a request transfers at a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, so requests offered while busy are simply
// not taken (nothing is queued). resp_valid is a one-cycle pulse; resp_err
// qualifies it, and resp_rdata holds the last load result until the next load.
module mem_access_unit #(
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_access_unit_if.slave     bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_lane;
  logic [2:0]        lat_funct3;
  logic              lat_write;
  logic [31:0]       lat_wdata;
  logic              lat_err;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              req_bad;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;
  logic [31:0]       merge_val;

  // Address bits above the memory word index are ignored by design.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

  assign accept = bus.req_valid && (state == IDLE);

  // Classify the incoming request: illegal size code or misaligned address.
  always_comb begin
    req_bad = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = bus.req_addr[0];
      3'b010:  req_bad = |bus.req_addr[1:0];
      3'b100:  req_bad = bus.req_write;
      3'b101:  req_bad = bus.req_write | bus.req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: errors skip memory, SW writes directly, SB/SH read first.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_bad) begin
            next_state = RESP;
          end else if (!bus.req_write) begin
            next_state = RD;
          end else if (bus.req_funct3 == 3'b010) begin
            next_state = WR;
          end else begin
            next_state = RD;
          end
        end
      end
      RD:      next_state = lat_write ? WR : RESP;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the accepted request for the whole operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_addr   <= '0;
      lat_lane   <= 2'b00;
      lat_funct3 <= 3'b000;
      lat_write  <= 1'b0;
      lat_wdata  <= 32'h0;
      lat_err    <= 1'b0;
    end else if (accept) begin
      lat_addr   <= bus.req_addr[ADDR_W+1:2];
      lat_lane   <= bus.req_addr[1:0];
      lat_funct3 <= bus.req_funct3;
      lat_write  <= bus.req_write;
      lat_wdata  <= bus.req_wdata;
      lat_err    <= req_bad;
    end
  end

  // Capture memory data at the RD exit edge: the old word for RMW, the load result otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
    end else if (state == RD) begin
      if (lat_write) begin
        word_q <= bus.mem_rdata;
      end else begin
        rdata_q <= load_val;
      end
    end
  end

  // Select the addressed lane of the memory word and extend it.
  always_comb begin
    byte_sel = 8'h00;
    case (lat_lane)
      2'd0:    byte_sel = bus.mem_rdata[7:0];
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      default: byte_sel = bus.mem_rdata[31:24];
    endcase
    half_sel = lat_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_val = bus.mem_rdata;
    case (lat_funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h000000, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0000, half_sel};
      default: load_val = bus.mem_rdata;
    endcase
  end

  // Build the store word: full word for SW, captured word with lanes replaced for SB/SH.
  always_comb begin
    merge_val = word_q;
    case (lat_funct3)
      3'b000: begin
        case (lat_lane)
          2'd0:    merge_val[7:0]   = lat_wdata[7:0];
          2'd1:    merge_val[15:8]  = lat_wdata[7:0];
          2'd2:    merge_val[23:16] = lat_wdata[7:0];
          default: merge_val[31:24] = lat_wdata[7:0];
        endcase
      end
      3'b001: begin
        if (lat_lane[1]) begin
          merge_val[31:16] = lat_wdata[15:0];
        end else begin
          merge_val[15:0] = lat_wdata[15:0];
        end
      end
      default: merge_val = lat_wdata;
    endcase
  end

  // Outputs decoded from state; memory strobes and response are masked while in reset.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.mem_read   = rst_n && (state == RD);
    bus.mem_write  = rst_n && (state == WR);
    bus.mem_addr   = ((state == RD) || (state == WR)) ? lat_addr : '0;
    bus.mem_wdata  = (state == WR) ? merge_val : 32'h0;
    bus.resp_valid = rst_n && (state == RESP);
    bus.resp_err   = rst_n && (state == RESP) && lat_err;
    bus.resp_rdata = rdata_q;
    dbg_state      = state;
  end

endmodule
